clock_enable_gen: RTL
=====================

# clock_enable_gen

Parametrised clock-control block for the system clock domain: it qualifies the PLL lock, sequences a clean system reset, and generates `NUM_CH` independently programmable single-cycle clock-enable strobes. Downstream logic (display timing, SPI, UART) runs on the one global system clock and uses these strobes instead of derived clocks. The block sits directly after the global clock buffer and feeds reset and enables to the rest of the design.

## Interface
- `NUM_CH`, 4: number of enable channels (1–8).
- `DIV_W`, 16: width of each channel's divide value.
- `DEFAULT_DIV`, 50: divide value loaded into every channel at reset.
- `RST_HOLD`, 1024: cycles the synchronised lock must stay high before reset releases (≥2).
- `SYNC_STAGES`, 2: flops in the lock synchroniser (≥2).
- `i_sys_clk`  in  1  system clock; the only clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_pll_lock`  in  1  PLL lock. Asynchronous; it is synchronised internally.
- `i_div_wr`  in  NUM_CH  per-channel write strobe for the divide value.
- `i_div_val`  in  DIV_W  divide value, written to every channel whose `i_div_wr` bit is set.
- `i_resync`  in  1  restarts all channel counters phase-aligned.
- `o_sys_rst`  out  1  downstream reset: asserts asynchronously, deasserts synchronously.
- `o_ce`  out  NUM_CH  enable strobes, one cycle wide.
- `o_lock_lost`  out  1  sticky flag: lock dropped while in RUN.

## Operation
- **Lock synchroniser**
  - `SYNC_STAGES` flops, all reset to 0.
  - Output `lock_s`.
- **State machine: WAIT_LOCK, HOLD, RUN**
  - `i_rst` forces WAIT_LOCK. It also sets `o_sys_rst`=1, `o_ce`=0, `o_lock_lost`=0, hold counter=0, all channel counters=0 and all divide registers=`DEFAULT_DIV`.
  - WAIT_LOCK: when `lock_s`=1, go to HOLD with hold counter=0.
  - HOLD: hold counter increments each cycle.
    - If `lock_s`=0, go to WAIT_LOCK and clear the hold counter.
    - When hold counter = `RST_HOLD`-1 and `lock_s`=1, go to RUN.
  - RUN: `o_sys_rst`=0.
    - If `lock_s`=0, go to WAIT_LOCK, set `o_sys_rst`=1 on the next cycle, and set `o_lock_lost`=1.
    - `o_lock_lost` stays 1 until `i_rst`.
  - `o_sys_rst`=1 in WAIT_LOCK and HOLD. It is registered, with no combinational path from inputs.
- **Channels (each k)**
  - Each channel has an active divide N, a shadow value, a pending flag, and a counter of width DIV_W.
  - N=0 is treated as N=1.
  - Outside RUN: counter held at 0, `o_ce[k]`=0, and writes update the active N immediately.
  - In RUN: counter runs 0..N-1 and wraps to 0. `o_ce[k]`=1 exactly in the cycle where counter = N-1. With N=1, `o_ce[k]` is continuously high.
  - A write in RUN goes to the shadow and sets pending. At the next wrap (counter N-1→0), shadow→active and pending clears. The period in progress is never truncated or stretched.
  - A write in the same cycle as a wrap applies to the period starting after that wrap.
  - A second write before the wrap overwrites the shadow; last write wins.
  - `i_resync` high in RUN: next cycle, all counters = 0 and all pending shadows are applied. A write in the same cycle as `i_resync` is applied.
  - `i_resync` takes priority over a wrap in the same cycle.
  - `i_resync` is ignored outside RUN.
- `o_ce` is forced to 0 in the cycle `o_sys_rst` re-asserts.

## Timing
- `i_pll_lock` rising to `lock_s` rising: `SYNC_STAGES` cycles.
- From `lock_s` rising with lock held stable, `o_sys_rst` falls after `RST_HOLD`+1 cycles.
- Reference cycle t0 = first cycle with `o_sys_rst`=0. Counters = 0 at t0.
- `o_ce[k]` pulses at t0+N-1, t0+2N-1, and so on.
- Lock loss: `lock_s` falls in cycle t, giving `o_sys_rst`=1 and `o_ce`=0 from t+1.
- Resync: `i_resync` sampled at cycle t gives counters = 0 at t+1. The next pulse is at t+N; with N=1, at t+1.
- `i_rst` assertion clears all state with no clock required.

## Test plan
- **Reset release:** `RST_HOLD`=16, `SYNC_STAGES`=2, raise `i_pll_lock` at cycle 10 → `o_sys_rst` falls at cycle 10+2+17; `o_ce`=0 throughout reset.
- **Divide:** channels set to 1, 2, 5, 0 → ch0 high every cycle from t0; ch1 at t0+1, t0+3, …; ch2 at t0+4, t0+9, …; ch3 identical to ch0.
- **Runtime change:** ch2 with N=5, write 3 when counter=1 → next pulse still at counter 4 (period 5); following pulses every 3 cycles. Also write on the wrap cycle → new period applies immediately after that wrap.
- **Resync:** ch1 N=4, ch2 N=6, pulse `i_resync` at cycle t → both counters 0 at t+1; ch1 pulses at t+4, ch2 at t+6; a write to ch1 of 2 in the same cycle gives a ch1 pulse at t+2.
- **Lock glitch:**
  - Drop lock for 1 cycle during HOLD → hold counter restarts; `o_lock_lost` stays 0.
  - Drop lock in RUN → `o_sys_rst`=1 `SYNC_STAGES`+1 cycles later and `o_lock_lost`=1; after relock and `RST_HOLD`, RUN resumes with `o_lock_lost` still 1.
- **Async reset mid-RUN:** assert `i_rst` between clock edges → all outputs at reset values immediately; divide registers = `DEFAULT_DIV`.

Source files
------------

// File: rtl/clock_enable_gen.sv
// rtl/clock_enable_gen.sv - PLL lock qualification, reset sequencing and clock-enable strobes
//
// Purpose: synchronises the PLL lock, holds the system reset until lock has
// been stable for RST_HOLD cycles, and produces NUM_CH single-cycle enable
// strobes with independently programmable divide values.
//
// Ports:
//   i_sys_clk    system clock (only clock)
//   i_rst        asynchronous active-high reset
//   i_pll_lock   asynchronous PLL lock
//   i_div_wr     per-channel divide write strobe
//   i_div_val    divide value for the channels selected by i_div_wr
//   i_resync     restart all channel counters phase-aligned
//   o_sys_rst    downstream reset (async assert, sync deassert)
//   o_ce         per-channel enable strobes
//   o_lock_lost  sticky: lock dropped while running

module clock_enable_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 50,
  parameter int RST_HOLD    = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic              i_pll_lock,
  input  logic [NUM_CH-1:0] i_div_wr,
  input  logic [DIV_W-1:0]  i_div_val,
  input  logic              i_resync,
  output logic              o_sys_rst,
  output logic [NUM_CH-1:0] o_ce,
  output logic              o_lock_lost
);

  localparam int HOLD_W = $clog2(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     lock_s;
  logic [HOLD_W-1:0]        hold_cnt;

  logic [DIV_W-1:0]         div_act    [NUM_CH];
  logic [DIV_W-1:0]         div_shadow [NUM_CH];
  logic [DIV_W-1:0]         cnt        [NUM_CH];
  logic [DIV_W-1:0]         last       [NUM_CH];
  logic [NUM_CH-1:0]        pend;
  logic [NUM_CH-1:0]        wrap;
  logic                     run;
  logic                     chan_run;

  // Lock synchroniser
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign run    = (state == RUN);
  // Channels only keep counting while RUN will persist into the next cycle;
  // on the cycle lock is seen to drop they already behave as stopped.
  assign chan_run = run && lock_s;

  // Reset sequencer
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= WAIT_LOCK;
      hold_cnt    <= '0;
      o_sys_rst   <= 1'b1;
      o_lock_lost <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          hold_cnt <= '0;
          if (lock_s) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            o_sys_rst <= 1'b0;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state       <= WAIT_LOCK;
            o_sys_rst   <= 1'b1;
            o_lock_lost <= 1'b1;
          end
        end
        default: begin
          state     <= WAIT_LOCK;
          hold_cnt  <= '0;
          o_sys_rst <= 1'b1;
        end
      endcase
    end
  end

  // Terminal count per channel; a divide of 0 behaves as 1.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      last[k] = (div_act[k] == '0) ? '0 : div_act[k] - DIV_W'(1);
      wrap[k] = (cnt[k] == last[k]);
    end
  end

  // Channel counters and divide registers. A write while running is parked
  // in the shadow and only becomes active at a period boundary (wrap or
  // resync), so the period in flight keeps its length.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      pend <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k]        <= '0;
        div_act[k]    <= DIV_W'(DEFAULT_DIV);
        div_shadow[k] <= DIV_W'(DEFAULT_DIV);
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!chan_run) begin
          cnt[k]  <= '0;
          pend[k] <= 1'b0;
          if (i_div_wr[k]) begin
            div_act[k] <= i_div_val;
          end else if (pend[k]) begin
            div_act[k] <= div_shadow[k];
          end
        end else if (i_resync || wrap[k]) begin
          cnt[k]  <= '0;
          pend[k] <= 1'b0;
          if (i_div_wr[k]) begin
            div_act[k] <= i_div_val;
          end else if (pend[k]) begin
            div_act[k] <= div_shadow[k];
          end
        end else begin
          cnt[k] <= cnt[k] + DIV_W'(1);
          if (i_div_wr[k]) begin
            div_shadow[k] <= i_div_val;
            pend[k]       <= 1'b1;
          end
        end
      end
    end
  end

  // Strobes decode registered state only, so they drop together with the
  // state leaving RUN and clear immediately on i_rst.
  always_comb begin
    o_ce = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      o_ce[k] = run && wrap[k];
    end
  end

endmodule
